// File: rtl/conv_window_feeder_if.sv
// Read-address/data bus to the IFM and weight buffers plus the element stream to the PE.
// The feeder drives addresses, strobes and the PE stream; the buffer side returns read data.
interface conv_window_feeder_if #(
   parameter int DATA_W = 8,
   parameter int IFM_AW = 12,
   parameter int W_AW   = 7
);
   logic [IFM_AW-1:0] ifm_addr;
   logic              ifm_rd_en;
   logic [DATA_W-1:0] ifm_rdata;
   logic [W_AW-1:0]   w_addr;
   logic              w_rd_en;
   logic [DATA_W-1:0] w_rdata;
   logic [DATA_W-1:0] IFM;
   logic [DATA_W-1:0] Weight;
   logic              PE_en;
   logic              PE_finish;

   modport master (
      output ifm_addr, ifm_rd_en, w_addr, w_rd_en, IFM, Weight, PE_en, PE_finish,
      input  ifm_rdata, w_rdata
   );

   modport slave (
      input  ifm_addr, ifm_rd_en, w_addr, w_rd_en, IFM, Weight, PE_en, PE_finish,
      output ifm_rdata, w_rdata
   );
endinterface

// File: rtl/conv_window_feeder.sv
// Walks a valid-padding stride-1 KxK convolution, issuing IFM/weight reads and framing
// each window's product stream with PE_en on the first element and PE_finish after the last.
module conv_window_feeder #(
   parameter int IMG_W   = 32,
   parameter int IMG_H   = 32,
   parameter int CH      = 3,
   parameter int K       = 3,
   parameter int FILTERS = 3,
   parameter int DATA_W  = 8,
   parameter int IFM_AW  = 12,
   parameter int W_AW    = 7
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic busy,
   output logic done,
   conv_window_feeder_if.master bus
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int KW  = $clog2(K + 1);
   localparam int CHW = $clog2(CH + 1);
   localparam int XW  = $clog2(IMG_W + 1);
   localparam int YW  = $clog2(IMG_H + 1);
   localparam int FW  = $clog2(FILTERS + 1);

   localparam logic [KW-1:0]  K_MAX  = KW'(K - 1);
   localparam logic [CHW-1:0] CH_MAX = CHW'(CH - 1);
   localparam logic [XW-1:0]  C_MAX  = XW'(IMG_W - K);
   localparam logic [YW-1:0]  R_MAX  = YW'(IMG_H - K);
   localparam logic [FW-1:0]  F_MAX  = FW'(FILTERS - 1);

   // Address deltas when an inner counter wraps into the next outer one.
   localparam logic [IFM_AW-1:0] ROW_STEP  = IFM_AW'(IMG_W - K + 1);
   localparam logic [IFM_AW-1:0] CH_STEP   = IFM_AW'(IMG_H * IMG_W - (K - 1) * IMG_W - (K - 1));
   localparam logic [IFM_AW-1:0] WROW_STEP = IFM_AW'(K);
   localparam logic [W_AW-1:0]   F_STEP    = W_AW'(CH * K * K);

   logic [1:0]        state_q, state_d;
   logic              issue_q, issue_d;
   logic              bub_q, bub_d;
   logic [KW-1:0]     kx_q, kx_d, ky_q, ky_d;
   logic [CHW-1:0]    ch_q, ch_d;
   logic [XW-1:0]     c_q, c_d;
   logic [YW-1:0]     r_q, r_d;
   logic [FW-1:0]     f_q, f_d;
   logic [IFM_AW-1:0] ifm_addr_q, ifm_addr_d, winb_q, winb_d;
   logic [W_AW-1:0]   w_addr_q, w_addr_d, wfb_q, wfb_d;
   // Slot tags: tag1 = {fin, bubble, first, valid}, tag2 drops valid.
   logic [3:0]        tag1_q, tag1_d;
   logic [2:0]        tag2_q, tag2_d;
   logic [DATA_W-1:0] ifm_o_q, ifm_o_d, w_o_q, w_o_d;
   logic              last_win;

   assign last_win = (c_q == C_MAX) && (r_q == R_MAX) && (f_q == F_MAX);

   always_comb begin
      state_d    = state_q;
      issue_d    = issue_q;
      bub_d      = bub_q;
      kx_d       = kx_q;
      ky_d       = ky_q;
      ch_d       = ch_q;
      c_d        = c_q;
      r_d        = r_q;
      f_d        = f_q;
      ifm_addr_d = ifm_addr_q;
      w_addr_d   = w_addr_q;
      winb_d     = winb_q;
      wfb_d      = wfb_q;
      tag1_d     = 4'b0000;
      tag2_d     = tag1_q[3:1];
      ifm_o_d    = tag1_q[0] ? bus.ifm_rdata : '0;
      w_o_d      = tag1_q[0] ? bus.w_rdata : '0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = RUN;
               issue_d    = 1'b1;
               bub_d      = 1'b0;
               kx_d       = '0;
               ky_d       = '0;
               ch_d       = '0;
               c_d        = '0;
               r_d        = '0;
               f_d        = '0;
               ifm_addr_d = '0;
               w_addr_d   = '0;
               winb_d     = '0;
               wfb_d      = '0;
            end
         end
         RUN: begin
            if (issue_q && !bub_q) begin
               tag1_d = {2'b00, (kx_q == '0) && (ky_q == '0) && (ch_q == '0), 1'b1};
               if (kx_q != K_MAX) begin
                  kx_d       = kx_q + 1'b1;
                  ifm_addr_d = ifm_addr_q + 1'b1;
                  w_addr_d   = w_addr_q + 1'b1;
               end else begin
                  kx_d = '0;
                  if (ky_q != K_MAX) begin
                     ky_d       = ky_q + 1'b1;
                     ifm_addr_d = ifm_addr_q + ROW_STEP;
                     w_addr_d   = w_addr_q + 1'b1;
                  end else begin
                     ky_d = '0;
                     if (ch_q != CH_MAX) begin
                        ch_d       = ch_q + 1'b1;
                        ifm_addr_d = ifm_addr_q + CH_STEP;
                        w_addr_d   = w_addr_q + 1'b1;
                     end else begin
                        ch_d  = '0;
                        bub_d = 1'b1;
                     end
                  end
               end
            end else if (issue_q) begin
               // Bubble slot: strobes low, then jump to the next window's base.
               tag1_d = {last_win, 1'b1, 2'b00};
               bub_d  = 1'b0;
               if (c_q != C_MAX) begin
                  c_d    = c_q + 1'b1;
                  winb_d = winb_q + 1'b1;
               end else begin
                  c_d = '0;
                  if (r_q != R_MAX) begin
                     r_d    = r_q + 1'b1;
                     winb_d = winb_q + WROW_STEP;
                  end else begin
                     r_d    = '0;
                     winb_d = '0;
                     if (f_q != F_MAX) begin
                        f_d   = f_q + 1'b1;
                        wfb_d = wfb_q + F_STEP;
                     end else begin
                        f_d     = '0;
                        wfb_d   = '0;
                        issue_d = 1'b0;
                     end
                  end
               end
               ifm_addr_d = winb_d;
               w_addr_d   = wfb_d;
            end
            if (tag2_q[2]) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         issue_q    <= 1'b0;
         bub_q      <= 1'b0;
         kx_q       <= '0;
         ky_q       <= '0;
         ch_q       <= '0;
         c_q        <= '0;
         r_q        <= '0;
         f_q        <= '0;
         ifm_addr_q <= '0;
         w_addr_q   <= '0;
         winb_q     <= '0;
         wfb_q      <= '0;
         tag1_q     <= '0;
         tag2_q     <= '0;
         ifm_o_q    <= '0;
         w_o_q      <= '0;
      end else begin
         state_q    <= state_d;
         issue_q    <= issue_d;
         bub_q      <= bub_d;
         kx_q       <= kx_d;
         ky_q       <= ky_d;
         ch_q       <= ch_d;
         c_q        <= c_d;
         r_q        <= r_d;
         f_q        <= f_d;
         ifm_addr_q <= ifm_addr_d;
         w_addr_q   <= w_addr_d;
         winb_q     <= winb_d;
         wfb_q      <= wfb_d;
         tag1_q     <= tag1_d;
         tag2_q     <= tag2_d;
         ifm_o_q    <= ifm_o_d;
         w_o_q      <= w_o_d;
      end
   end

   assign busy          = (state_q == RUN);
   assign done          = (state_q == DONE);
   assign bus.ifm_addr  = ifm_addr_q;
   assign bus.w_addr    = w_addr_q;
   assign bus.ifm_rd_en = busy && issue_q && !bub_q;
   assign bus.w_rd_en   = busy && issue_q && !bub_q;
   assign bus.IFM       = ifm_o_q;
   assign bus.Weight    = w_o_q;
   assign bus.PE_en     = tag2_q[0];
   assign bus.PE_finish = tag2_q[1];
endmodule

// File: tb/tb_conv_window_feeder.sv
// Directed bench for conv_window_feeder: default 32x32x3 layer plus a minimal 3x3 single-window layer.
module tb_conv_window_feeder;
   localparam int N = 2700;
   localparam int P = 28;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start0 = 1'b0;
   logic start1 = 1'b0;
   logic busy0, done0, busy1, done1;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   conv_window_feeder_if #(.DATA_W(8), .IFM_AW(12), .W_AW(7)) bus0 ();
   conv_window_feeder_if #(.DATA_W(8), .IFM_AW(4),  .W_AW(4)) bus1 ();

   conv_window_feeder u0 (
      .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0), .bus(bus0)
   );

   conv_window_feeder #(
      .IMG_W(3), .IMG_H(3), .CH(1), .K(3), .FILTERS(1), .DATA_W(8), .IFM_AW(4), .W_AW(4)
   ) u1 (
      .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1), .bus(bus1)
   );

   function automatic logic [7:0] ifm_fn(input int a);
      return 8'(a * 7 + 3);
   endfunction

   function automatic logic [7:0] w_fn(input int a);
      return 8'(a * 5 + 11);
   endfunction

   // Synchronous-read buffer models
   always @(posedge clk) begin
      if (bus0.ifm_rd_en) bus0.ifm_rdata <= ifm_fn(int'(bus0.ifm_addr));
      if (bus0.w_rd_en)   bus0.w_rdata   <= w_fn(int'(bus0.w_addr));
      if (bus1.ifm_rd_en) bus1.ifm_rdata <= ifm_fn(int'(bus1.ifm_addr));
      if (bus1.w_rd_en)   bus1.w_rdata   <= w_fn(int'(bus1.w_addr));
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int fin_cnt, en_cnt, coinc, bad_en, bad_fin, early_done, busy_drop;
      int rd_cnt, done_cnt;
      int exp_a, k, w, kk;
      fin_cnt = 0; en_cnt = 0; coinc = 0; bad_en = 0; bad_fin = 0;
      early_done = 0; busy_drop = 0; rd_cnt = 0; done_cnt = 0;
      bus0.ifm_rdata = '0; bus0.w_rdata = '0;
      bus1.ifm_rdata = '0; bus1.w_rdata = '0;

      repeat (3) step();
      check("rst_busy",      32'(busy0),           0);
      check("rst_done",      32'(done0),           0);
      check("rst_ifm_addr",  32'(bus0.ifm_addr),   0);
      check("rst_w_addr",    32'(bus0.w_addr),     0);
      check("rst_rd_en",     32'(bus0.ifm_rd_en),  0);
      check("rst_IFM",       32'(bus0.IFM),        0);
      check("rst_PE_en",     32'(bus0.PE_en),      0);
      check("rst_PE_finish", 32'(bus0.PE_finish),  0);
      reset = 1'b0;
      step();

      // Full default layer
      start0 = 1'b1;
      step();
      start0 = 1'b0;
      for (int t = 0; t <= P * N + 2; t++) begin
         if (t < 27) begin
            exp_a = (t / 9) * 1024 + ((t % 9) / 3) * 32 + (t % 3);
            check("win0_ifm_addr", 32'(bus0.ifm_addr), 32'(exp_a));
            check("win0_w_addr",   32'(bus0.w_addr),   32'(t));
            check("win0_rd_en",    32'(bus0.ifm_rd_en), 1);
         end
         if (t == 27) begin
            check("bubble_ifm_strobe", 32'(bus0.ifm_rd_en), 0);
            check("bubble_w_strobe",   32'(bus0.w_rd_en),   0);
         end
         if (t >= 2 && t < 29) begin
            kk = t - 2;
            exp_a = (kk / 9) * 1024 + ((kk % 9) / 3) * 32 + (kk % 3);
            check("win0_IFM",    32'(bus0.IFM),    32'(ifm_fn(exp_a)));
            check("win0_Weight", 32'(bus0.Weight), 32'(w_fn(kk)));
            check("win0_PE_en",  32'(bus0.PE_en),  32'(kk == 0));
         end
         if (t == 29) begin
            check("win0_PE_finish", 32'(bus0.PE_finish), 1);
            check("win0_fin_IFM",   32'(bus0.IFM),       0);
            check("win0_fin_Weight",32'(bus0.Weight),    0);
         end
         w = t / P;
         k = t % P;
         if (w == 29 && k == 26)    check("colwrap_end_ifm",   32'(bus0.ifm_addr), 2143);
         if (w == 30 && k == 0) begin
            check("colwrap_next_ifm", 32'(bus0.ifm_addr), 32);
            check("colwrap_next_w",   32'(bus0.w_addr),   0);
         end
         if (w == 900 && k == 0) begin
            check("filter1_w",   32'(bus0.w_addr),   27);
            check("filter1_ifm", 32'(bus0.ifm_addr), 0);
         end
         if (w == N - 1 && k == 26) begin
            check("last_w",   32'(bus0.w_addr),   80);
            check("last_ifm", 32'(bus0.ifm_addr), 3071);
         end
         if (bus0.PE_finish) fin_cnt++;
         if (bus0.PE_en) en_cnt++;
         if (bus0.PE_en && bus0.PE_finish) coinc++;
         if (bus0.PE_en && (t < 2 || (t - 2) % P != 0)) bad_en++;
         if (bus0.PE_finish && (t < 2 || (t - 2) % P != 27)) bad_fin++;
         if (t < P * N + 2) begin
            if (done0) early_done++;
            if (!busy0) busy_drop++;
         end
         if (t == 100) start0 = 1'b1;
         if (t == 101) start0 = 1'b0;
         if (t == P * N + 2) begin
            check("done_pulse", 32'(done0), 1);
            check("done_busy",  32'(busy0), 0);
            start0 = 1'b1;
         end else begin
            step();
         end
      end
      check("pe_finish_count", 32'(fin_cnt),    32'(N));
      check("pe_en_count",     32'(en_cnt),     32'(N));
      check("en_finish_overlap", 32'(coinc),    0);
      check("pe_en_timing",    32'(bad_en),     0);
      check("pe_finish_timing",32'(bad_fin),    0);
      check("early_done",      32'(early_done), 0);
      check("busy_dropped",    32'(busy_drop),  0);

      // start during DONE is ignored
      step();
      start0 = 1'b0;
      check("start_in_done_idle", 32'(busy0), 0);
      step();
      check("start_in_done_still_idle", 32'(busy0), 0);

      // Mid-window asynchronous reset
      start0 = 1'b1;
      step();
      start0 = 1'b0;
      repeat (10) step();
      #3;
      reset = 1'b1;
      #1;
      check("async_rst_busy",     32'(busy0),          0);
      check("async_rst_rd_en",    32'(bus0.ifm_rd_en), 0);
      check("async_rst_ifm_addr", 32'(bus0.ifm_addr),  0);
      check("async_rst_w_addr",   32'(bus0.w_addr),    0);
      check("async_rst_IFM",      32'(bus0.IFM),       0);
      check("async_rst_Weight",   32'(bus0.Weight),    0);
      step();
      reset = 1'b0;
      step();
      check("post_rst_idle", 32'(busy0), 0);
      start0 = 1'b1;
      step();
      start0 = 1'b0;
      check("restart_busy",     32'(busy0),          1);
      check("restart_ifm_addr", 32'(bus0.ifm_addr),  0);
      check("restart_w_addr",   32'(bus0.w_addr),    0);
      check("restart_rd_en",    32'(bus0.ifm_rd_en), 1);

      // Minimal single-window layer
      en_cnt = 0; fin_cnt = 0;
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      for (int t = 0; t < 16; t++) begin
         if (bus1.PE_en) en_cnt++;
         if (bus1.PE_finish) fin_cnt++;
         if (bus1.ifm_rd_en) rd_cnt++;
         if (done1) done_cnt++;
         if (t == 2)  check("min_PE_en", 32'(bus1.PE_en), 1);
         if (t == 6) begin
            check("min_IFM_k4",    32'(bus1.IFM),    32'(ifm_fn(4)));
            check("min_Weight_k4", 32'(bus1.Weight), 32'(w_fn(4)));
         end
         if (t == 11) check("min_PE_finish", 32'(bus1.PE_finish), 1);
         if (t == 12) begin
            check("min_done", 32'(done1), 1);
            check("min_busy", 32'(busy1), 0);
         end
         step();
      end
      check("min_en_count",   32'(en_cnt),   1);
      check("min_fin_count",  32'(fin_cnt),  1);
      check("min_data_cycles",32'(rd_cnt),   9);
      check("min_done_count", 32'(done_cnt), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/conv_window_feeder.md
# conv_window_feeder

Upstream stage of the convolution processing element. Walks a valid-padding, stride-1 KxK convolution over a channel-planar input feature map. Issues synchronous-read addresses to the IFM and weight buffers and streams the returned byte pairs to the PE. Frames each output pixel with a one-cycle `PE_en` on its first product and a one-cycle `PE_finish` after its last, so the PE emits one OFM byte per window.

## Interface
- `IMG_W`, 32: input width in pixels
- `IMG_H`, 32: input height in pixels
- `CH`, 3: input channels
- `K`, 3: kernel side
- `FILTERS`, 3: output filters
- `DATA_W`, 8: element width
- `IFM_AW`, 12: IFM address width; must hold CH·IMG_H·IMG_W−1
- `W_AW`, 7: weight address width; must hold FILTERS·CH·K·K−1

Ports:
- `clk` in 1: clock, rising edge
- `reset` in 1: asynchronous, active-high
- `start` in 1: one-cycle request to run a full layer
- `busy` out 1: layer in progress
- `done` out 1: one-cycle pulse at layer completion
- `ifm_addr` out IFM_AW: IFM buffer read address
- `ifm_rd_en` out 1: IFM read strobe
- `ifm_rdata` in DATA_W: IFM data, valid one cycle after the strobe
- `w_addr` out W_AW: weight buffer read address
- `w_rd_en` out 1: weight read strobe
- `w_rdata` in DATA_W: weight data, valid one cycle after the strobe
- `IFM` out DATA_W: element to PE
- `Weight` out DATA_W: weight to PE
- `PE_en` out 1: first product of a window
- `PE_finish` out 1: window closed

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN when `start` is sampled high. DONE lasts one cycle and returns to IDLE. `start` outside IDLE is ignored.
- Loop order, outer to inner: filter f, output row r (0..IMG_H−K), output col c (0..IMG_W−K), channel ch, ky, kx.
- `ifm_addr` = ch·IMG_H·IMG_W + (r+ky)·IMG_W + (c+kx).
- `w_addr` = f·CH·K·K + ch·K·K + ky·K + kx.
- Addresses come from incremental counters. No runtime multipliers except the constant channel and filter strides.
- Each window is K·K·CH issue slots followed by one bubble slot (strobes low, addresses held). Period = K·K·CH+1 cycles.
- Per slot, a 2-stage tag pipeline carries {valid, first, last}:
  - `IFM`/`Weight` register `ifm_rdata`/`w_rdata` when the stage-2 tag is valid; otherwise they drive 0.
  - `PE_en` = stage-2 first. `PE_finish` = stage-2 bubble.
- Total windows N = FILTERS·(IMG_H−K+1)·(IMG_W−K+1). Defaults: N=2700, 28-cycle period, 75 600 stream cycles.
- Reset: all outputs 0 and state IDLE, immediately and asynchronously, including mid-layer. No partial window resumes; the next `start` begins at f=r=c=0.

## Timing
- `start` sampled at edge E0: `busy`=1 after E0, and slot 0 addresses with strobes high after E0.
- Element k of window w appears on `IFM`/`Weight` after edge E2 + 28w + k. `PE_en`=1 only for k=0.
- `PE_finish`=1 after E2 + 28w + 27, with `IFM`=`Weight`=0 that cycle.
- `PE_en` and `PE_finish` never coincide.
- After the last `PE_finish`, the next cycle has `done`=1 and `busy`=0 together. A `start` in that cycle is ignored; one in the following cycle is accepted.
- Strobes are low in IDLE, DONE and bubble slots.
- Counter wrap: kx→ky→ch→c→r→f. Any carry out of ch inserts the bubble before the next window begins.

## Test plan
- Reset → all outputs 0. Assert `reset` mid-window → outputs 0 asynchronously. Restart → first `ifm_addr`=0, `w_addr`=0.
- Defaults, first window: `ifm_addr` sequence 0,1,2,32,33,34,64,65,66,1024,…,2114. `w_addr` sequence 0..26. `PE_en` on element 0, `PE_finish` 27 cycles later.
- Column wrap: window c=29, r=0 ends at ifm_addr 2143. The next window (r=1, c=0) starts at ifm_addr 32.
- Filter transition: window 900 starts with `w_addr`=27 and `ifm_addr`=0. The last window ends with `w_addr`=80.
- Minimal config IMG_W=IMG_H=K=3, CH=FILTERS=1: exactly one `PE_en`, 9 data cycles, one `PE_finish`, `done` on the next cycle.
- `start` pulsed while `busy`: no restart, and the total `PE_finish` count stays at 2700.
